// File: rtl/rib_arb_n.sv
// -----------------------------------------------------------------------------
// rib_arb_n -- N-master / N-slave request/ready bus arbiter and address router.
//
// A two-state controller (IDLE/BUSY) grants one master at a time.  The grant
// is chosen in IDLE (fixed priority, highest index wins, or round-robin) and
// registered.  While BUSY, the granted master's address/data/we are steered
// combinationally to the slave selected by address bits [31:28].  The slave's
// ready closes the transfer: that cycle the master sees m_ready_o with the
// slave's read data, and the controller returns to IDLE.  There is always one
// IDLE (arbitration) cycle between transfers.
//
// Handshake: a master raises m_req_i and keeps req/addr/data/we stable until
// it samples its m_ready_o bit high; dropping m_req_i while granted aborts the
// transfer with no m_ready_o.  A slave completes the cycle it sees s_req_o
// with s_ready_i high; nothing is latched by the arbiter.
//
// Optional feature (macro RIB_ARB_TIMEOUT_EN): a BUSY-cycle watchdog that
// terminates a transfer after TIMEOUT cycles without slave ready, returning
// 32'hDEAD_BEEF and an error pulse.  Without the macro BUSY waits forever.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   m_req_i       per-master request         m_we_i    per-master write enable
//   m_addr_i      flattened master addresses m_data_i  flattened write data
//   m_data_o      read data to all masters   m_ready_o per-master completion
//   m_gnt_o       one-hot registered grant
//   s_addr_o      slave address ([31:28] zeroed)  s_data_o  slave write data
//   s_req_o       one-hot slave request      s_we_o    one-hot slave write
//   s_data_i      flattened slave read data  s_ready_i per-slave ready
//   hold_flag_o   stall request to core (master 0)
//   err_o         one-cycle error pulse (unmapped slave or watchdog)
// -----------------------------------------------------------------------------
module rib_arb_n #(
    parameter int NUM_M    = 4,
    parameter int NUM_S    = 8,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_M-1:0]      m_req_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [NUM_M*32-1:0]   m_addr_i,
    input  logic [NUM_M*32-1:0]   m_data_i,
    output logic [31:0]           m_data_o,
    output logic [NUM_M-1:0]      m_ready_o,
    output logic [NUM_M-1:0]      m_gnt_o,
    output logic [31:0]           s_addr_o,
    output logic [31:0]           s_data_o,
    output logic [NUM_S-1:0]      s_req_o,
    output logic [NUM_S-1:0]      s_we_o,
    input  logic [NUM_S*32-1:0]   s_data_i,
    input  logic [NUM_S-1:0]      s_ready_i,
    output logic                  hold_flag_o,
    output logic                  err_o
);
    localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam logic [MW-1:0] LAST_RST = MW'(NUM_M - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // All controller state in one struct so a checker can bind to regs.state.
    typedef struct packed {
        state_t           state;
        logic [NUM_M-1:0] gnt;
        logic [MW-1:0]    g_idx;
        logic [MW-1:0]    last_grant;
    } arb_regs_t;

    arb_regs_t      regs, regs_nxt;
    logic           win_any;
    logic [MW-1:0]  win_idx;
    logic [MW-1:0]  rr_c;
    logic [31:0]    g_addr;
    logic [31:0]    g_data;
    logic           g_req;
    logic           g_we;
    logic [3:0]     dec_idx;
    logic [SW-1:0]  s_idx;
    logic           s_valid;
    logic           done;

    // Granted master's bus, selected from the registered grant index.
    always_comb begin
        g_addr  = m_addr_i[int'(regs.g_idx)*32 +: 32];
        g_data  = m_data_i[int'(regs.g_idx)*32 +: 32];
        g_req   = m_req_i[regs.g_idx];
        g_we    = m_we_i[regs.g_idx];
        dec_idx = g_addr[31:28];
        s_idx   = dec_idx[SW-1:0];
        s_valid = ({28'd0, dec_idx} < 32'(NUM_S));
    end

    // Winner selection. Round-robin scans downward so the candidate closest
    // to last_grant+1 (wrapping) is the one that sticks.
    always_comb begin
        win_any = |m_req_i;
        win_idx = '0;
        rr_c    = '0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (m_req_i[i]) win_idx = MW'(i);
            end
        end else begin
            for (int k = NUM_M; k >= 1; k--) begin
                rr_c = MW'((int'(regs.last_grant) + k) % NUM_M);
                if (m_req_i[rr_c]) win_idx = rr_c;
            end
        end
    end

`ifdef RIB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] busy_cnt;
    logic          tmo_hit;

    // Held at zero outside BUSY, so it reads 0 in the first BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      busy_cnt <= '0;
        else if (regs.state != BUSY)  busy_cnt <= '0;
        else                          busy_cnt <= busy_cnt + CW'(1);
    end

    assign tmo_hit = (busy_cnt == CW'(TIMEOUT - 1));
`endif

    always_comb begin
        regs_nxt  = regs;
        done      = 1'b0;
        m_data_o  = '0;
        m_ready_o = '0;
        s_addr_o  = '0;
        s_data_o  = '0;
        s_req_o   = '0;
        s_we_o    = '0;
        err_o     = 1'b0;
        case (regs.state)
            IDLE: begin
                if (win_any) begin
                    regs_nxt.state        = BUSY;
                    regs_nxt.gnt          = '0;
                    regs_nxt.gnt[win_idx] = 1'b1;
                    regs_nxt.g_idx        = win_idx;
                end
            end
            BUSY: begin
                if (!g_req) begin
                    // Master withdrew: abort silently.
                    done = 1'b1;
                end else begin
                    s_addr_o = {4'h0, g_addr[27:0]};
                    s_data_o = g_data;
                    if (!s_valid) begin
                        // Unmapped slave: complete at once with error.
                        m_ready_o[regs.g_idx] = 1'b1;
                        err_o                 = 1'b1;
                        done                  = 1'b1;
                    end else begin
                        s_req_o[s_idx] = 1'b1;
                        s_we_o[s_idx]  = g_we;
                        if (s_ready_i[s_idx]) begin
                            m_ready_o[regs.g_idx] = 1'b1;
                            m_data_o              = s_data_i[int'(s_idx)*32 +: 32];
                            done                  = 1'b1;
                        end
`ifdef RIB_ARB_TIMEOUT_EN
                        else if (tmo_hit) begin
                            m_ready_o[regs.g_idx] = 1'b1;
                            m_data_o              = 32'hDEAD_BEEF;
                            err_o                 = 1'b1;
                            done                  = 1'b1;
                        end
`endif
                    end
                end
            end
            default: regs_nxt.state = IDLE;
        endcase
        if (done) begin
            regs_nxt.state      = IDLE;
            regs_nxt.gnt        = '0;
            regs_nxt.last_grant = regs.g_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs.state      <= IDLE;
            regs.gnt        <= '0;
            regs.g_idx      <= '0;
            regs.last_grant <= LAST_RST;
        end else begin
            regs <= regs_nxt;
        end
    end

    assign m_gnt_o     = regs.gnt;
    // Forced low during reset so every output reads 0 while rst is high.
    assign hold_flag_o = !rst && ((|m_req_i[NUM_M-1:1]) ||
                                  (regs.state == BUSY && !regs.gnt[0]));

endmodule

// File: tb/tb_rib_arb_n.sv
// -----------------------------------------------------------------------------
// tb_rib_arb_n -- bench for rib_arb_n.  Two instances share clk/rst: dut 0 in
// fixed-priority mode, dut 1 in round-robin mode, each with its own inputs.
// Directed scenarios plus a randomized run checked cycle by cycle against a
// transaction-level model (owner / last-winner bookkeeping per instance).
// -----------------------------------------------------------------------------
module tb_rib_arb_n;
    localparam int NM = 4;
    localparam int NS = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;

    logic [NM-1:0]    m_req   [2];
    logic [NM-1:0]    m_we    [2];
    logic [NM*32-1:0] m_addr  [2];
    logic [NM*32-1:0] m_wdata [2];
    logic [NS*32-1:0] s_rdata [2];
    logic [NS-1:0]    s_ready [2];

    logic [31:0]      o_mdata [2];
    logic [NM-1:0]    o_ready [2];
    logic [NM-1:0]    o_gnt   [2];
    logic [31:0]      o_saddr [2];
    logic [31:0]      o_sdata [2];
    logic [NS-1:0]    o_sreq  [2];
    logic [NS-1:0]    o_swe   [2];
    logic             o_hold  [2];
    logic             o_err   [2];

    int total = 0;
    int bad   = 0;

    logic [NM-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    rib_arb_n #(.NUM_M(NM), .NUM_S(NS), .ARB_MODE(0), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .rst(rst),
        .m_req_i(m_req[0]), .m_we_i(m_we[0]), .m_addr_i(m_addr[0]), .m_data_i(m_wdata[0]),
        .m_data_o(o_mdata[0]), .m_ready_o(o_ready[0]), .m_gnt_o(o_gnt[0]),
        .s_addr_o(o_saddr[0]), .s_data_o(o_sdata[0]), .s_req_o(o_sreq[0]), .s_we_o(o_swe[0]),
        .s_data_i(s_rdata[0]), .s_ready_i(s_ready[0]),
        .hold_flag_o(o_hold[0]), .err_o(o_err[0])
    );

    rib_arb_n #(.NUM_M(NM), .NUM_S(NS), .ARB_MODE(1), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst(rst),
        .m_req_i(m_req[1]), .m_we_i(m_we[1]), .m_addr_i(m_addr[1]), .m_data_i(m_wdata[1]),
        .m_data_o(o_mdata[1]), .m_ready_o(o_ready[1]), .m_gnt_o(o_gnt[1]),
        .s_addr_o(o_saddr[1]), .s_data_o(o_sdata[1]), .s_req_o(o_sreq[1]), .s_we_o(o_swe[1]),
        .s_data_i(s_rdata[1]), .s_ready_i(s_ready[1]),
        .hold_flag_o(o_hold[1]), .err_o(o_err[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [NM-1:0] gnt;
        logic [NM-1:0] ready;
        logic [31:0]   mdata;
        logic [31:0]   saddr;
        logic [31:0]   sdata;
        logic [NS-1:0] sreq;
        logic [NS-1:0] swe;
        logic          hold;
        logic          err;
        logic          done;
    } exp_t;

    int mb_busy [2];
    int mb_own  [2];
    int mb_last [2];
    int mb_cnt  [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            mb_busy[d] = 0;
            mb_own[d]  = 0;
            mb_last[d] = NM - 1;
            mb_cnt[d]  = 0;
        end
    endfunction

    // Instance 0: highest requesting index. Instance 1: first requester
    // after the previous winner, wrapping.
    function automatic int pick(input int d);
        if (d == 0) begin
            for (int i = NM - 1; i >= 0; i--) if (m_req[d][i]) return i;
        end else begin
            for (int k = 1; k <= NM; k++) if (m_req[d][(mb_last[d] + k) % NM]) return (mb_last[d] + k) % NM;
        end
        return -1;
    endfunction

    function automatic exp_t model_expect(input int d);
        exp_t e;
        logic [31:0] a;
        int sidx;
        int g;
        e.gnt = '0; e.ready = '0; e.mdata = '0; e.saddr = '0; e.sdata = '0;
        e.sreq = '0; e.swe = '0; e.err = 1'b0; e.done = 1'b0;
        e.hold = |m_req[d][NM-1:1];
        if (mb_busy[d] != 0) begin
            g = mb_own[d];
            e.gnt = NM'(1) << g;
            if (g != 0) e.hold = 1'b1;
            if (!m_req[d][g]) begin
                e.done = 1'b1;
            end else begin
                a       = m_addr[d][g*32 +: 32];
                sidx    = int'(a[31:28]);
                e.saddr = a & 32'h0FFF_FFFF;
                e.sdata = m_wdata[d][g*32 +: 32];
                if (sidx >= NS) begin
                    e.ready = NM'(1) << g;
                    e.err   = 1'b1;
                    e.done  = 1'b1;
                end else begin
                    e.sreq = NS'(1) << sidx;
                    e.swe  = m_we[d][g] ? e.sreq : '0;
                    if (s_ready[d][sidx]) begin
                        e.ready = NM'(1) << g;
                        e.mdata = s_rdata[d][sidx*32 +: 32];
                        e.done  = 1'b1;
                    end
`ifdef RIB_ARB_TIMEOUT_EN
                    else if (mb_cnt[d] == TO - 1) begin
                        e.ready = NM'(1) << g;
                        e.mdata = 32'hDEAD_BEEF;
                        e.err   = 1'b1;
                        e.done  = 1'b1;
                    end
`endif
                end
            end
        end
        return e;
    endfunction

    function automatic void model_step(input int d, input exp_t e);
        int w;
        if (mb_busy[d] != 0) begin
            if (e.done) begin
                mb_busy[d] = 0;
                mb_last[d] = mb_own[d];
                mb_cnt[d]  = 0;
            end else begin
                mb_cnt[d]++;
            end
        end else begin
            w = pick(d);
            if (w >= 0) begin
                mb_busy[d] = 1;
                mb_own[d]  = w;
                mb_cnt[d]  = 0;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            m_req[d] = '0; m_we[d] = '0; m_addr[d] = '0; m_wdata[d] = '0;
            s_rdata[d] = '0; s_ready[d] = '0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_master(input int d, input int i, input logic we,
                              input logic [31:0] addr, input logic [31:0] data);
        m_req[d][i] = 1'b1;
        m_we[d][i]  = we;
        m_addr[d][i*32 +: 32]  = addr;
        m_wdata[d][i*32 +: 32] = data;
    endtask

    task automatic new_txn(input int d, input int i);
        logic [3:0] sl;
        sl = 4'($urandom_range(0, 9));
        set_master(d, i, 1'($urandom_range(0, 1)), {sl, 28'($urandom)}, $urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NM; i++) set_master(d, i, 1'b1, 32'h1000_0000, 32'h55);
        s_ready[0] = '1; s_ready[1] = '1;
        #3;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (o_gnt[d] !== '0 || o_ready[d] !== '0 || o_sreq[d] !== '0 || o_swe[d] !== '0) begin
                bad++; $display("FAIL reset_ctl d=%0d gnt=%h rdy=%h sreq=%h swe=%h want all 0", d, o_gnt[d], o_ready[d], o_sreq[d], o_swe[d]);
            end
            total++;
            if (o_mdata[d] !== 32'h0 || o_saddr[d] !== 32'h0 || o_sdata[d] !== 32'h0 || o_hold[d] !== 1'b0 || o_err[d] !== 1'b0) begin
                bad++; $display("FAIL reset_data d=%0d mdata=%h saddr=%h sdata=%h hold=%b err=%b want all 0", d, o_mdata[d], o_saddr[d], o_sdata[d], o_hold[d], o_err[d]);
            end
        end
        @(negedge clk); #1;
        total++;
        if (o_gnt[0] !== '0 || o_gnt[1] !== '0) begin
            bad++; $display("FAIL reset_hold_gnt got=%h/%h want 0/0", o_gnt[0], o_gnt[1]);
        end
        apply_reset();
    endtask

    task automatic test_basic_read();
        apply_reset();
        set_master(0, 1, 1'b0, 32'h1000_0010, 32'h0);
        s_ready[0][1] = 1'b1;
        s_rdata[0][1*32 +: 32] = 32'h1234_5678;
        #1;
        total++;
        if (o_gnt[0] !== 4'b0000 || o_ready[0] !== 4'b0000 || o_hold[0] !== 1'b1) begin
            bad++; $display("FAIL basic_idle gnt=%h rdy=%h hold=%b want 0 0 1", o_gnt[0], o_ready[0], o_hold[0]);
        end
        @(negedge clk); #1;
        total++;
        if (o_gnt[0] !== 4'b0010 || o_ready[0] !== 4'b0010) begin
            bad++; $display("FAIL basic_gnt gnt=%h rdy=%h want 2 2", o_gnt[0], o_ready[0]);
        end
        total++;
        if (o_mdata[0] !== 32'h1234_5678 || o_saddr[0] !== 32'h0000_0010) begin
            bad++; $display("FAIL basic_data mdata=%h saddr=%h want 12345678 00000010", o_mdata[0], o_saddr[0]);
        end
        total++;
        if (o_sreq[0] !== 8'h02 || o_swe[0] !== 8'h00 || o_err[0] !== 1'b0) begin
            bad++; $display("FAIL basic_sreq sreq=%h swe=%h err=%b want 02 00 0", o_sreq[0], o_swe[0], o_err[0]);
        end
        @(negedge clk);
        m_req[0] = '0; #1;
        total++;
        if (o_gnt[0] !== 4'b0000 || o_ready[0] !== 4'b0000 || o_mdata[0] !== 32'h0) begin
            bad++; $display("FAIL basic_after gnt=%h rdy=%h mdata=%h want 0", o_gnt[0], o_ready[0], o_mdata[0]);
        end
    endtask

    task automatic test_fixed_priority();
        logic [NM-1:0] pending;
        logic [NM-1:0] want;
        apply_reset();
        for (int i = 0; i < NM; i++) begin
            m_addr[0][i*32 +: 32] = 32'h0000_0100 + 32'(i);
            m_we[0][i] = 1'b1;
        end
        s_ready[0][0] = 1'b1;
        pending = 4'b1101;
        exp_q.delete();
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0100); exp_q.push_back(4'b0001);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            m_req[0] = pending;
            #1;
            total++;
            if (o_hold[0] !== (|pending[3:1])) begin
                bad++; $display("FAIL fp_hold cyc=%0d got=%b want=%b", c, o_hold[0], |pending[3:1]);
            end
            if (o_ready[0] != '0) begin
                want = exp_q.pop_front();
                total++;
                if (o_ready[0] !== want || o_gnt[0] !== want) begin
                    bad++; $display("FAIL fp_order rdy=%h gnt=%h want=%h", o_ready[0], o_gnt[0], want);
                end
                pending = pending & ~o_ready[0];
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL fp_timeout left=%0d want 0", exp_q.size());
        end
        @(negedge clk);
        m_req[0] = '0;
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] want;
        apply_reset();
        for (int i = 0; i < NM; i++) set_master(1, i, 1'b0, 32'h0000_0040 + 32'(i), 32'h0);
        s_ready[1][0] = 1'b1;
        s_rdata[1][31:0] = 32'hCAFE_0001;
        exp_q.delete();
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) begin
                @(negedge clk); #1;
            end
            if (k % 2 == 1) begin
                want = exp_q.pop_front();
                total++;
                if (o_gnt[1] !== want || o_ready[1] !== want || o_mdata[1] !== 32'hCAFE_0001) begin
                    bad++; $display("FAIL rr_grant k=%0d gnt=%h rdy=%h mdata=%h want=%h CAFE0001", k, o_gnt[1], o_ready[1], o_mdata[1], want);
                end
            end else begin
                total++;
                if (o_gnt[1] !== '0 || o_ready[1] !== '0) begin
                    bad++; $display("FAIL rr_idle k=%0d gnt=%h rdy=%h want 0", k, o_gnt[1], o_ready[1]);
                end
            end
        end
        @(negedge clk);
        m_req[1] = '0;
    endtask

    task automatic test_error();
        apply_reset();
        set_master(0, 2, 1'b1, 32'hF000_0000, 32'h1111_2222);
        s_ready[0] = '1;
        for (int j = 0; j < NS; j++) s_rdata[0][j*32 +: 32] = 32'hA5A5_0000 + 32'(j);
        @(negedge clk); #1;
        total++;
        if (o_ready[0] !== 4'b0100 || o_err[0] !== 1'b1 || o_mdata[0] !== 32'h0 || o_sreq[0] !== 8'h00 || o_swe[0] !== 8'h00) begin
            bad++; $display("FAIL err_cycle rdy=%h err=%b mdata=%h sreq=%h swe=%h want 4 1 0 00 00", o_ready[0], o_err[0], o_mdata[0], o_sreq[0], o_swe[0]);
        end
        @(negedge clk);
        m_req[0] = '0; #1;
        total++;
        if (o_err[0] !== 1'b0 || o_gnt[0] !== '0) begin
            bad++; $display("FAIL err_pulse err=%b gnt=%h want 0 0", o_err[0], o_gnt[0]);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        set_master(0, 1, 1'b1, 32'h2000_0004, 32'hBEEF_0042);
        @(negedge clk); #1;
        total++;
        if (o_sreq[0] !== 8'h04 || o_swe[0] !== 8'h04 || o_sdata[0] !== 32'hBEEF_0042 || o_ready[0] !== '0) begin
            bad++; $display("FAIL abort_busy sreq=%h swe=%h sdata=%h rdy=%h want 04 04 BEEF0042 0", o_sreq[0], o_swe[0], o_sdata[0], o_ready[0]);
        end
        m_req[0][1] = 1'b0; #1;
        total++;
        if (o_sreq[0] !== 8'h00 || o_ready[0] !== '0 || o_err[0] !== 1'b0) begin
            bad++; $display("FAIL abort_drop sreq=%h rdy=%h err=%b want 0", o_sreq[0], o_ready[0], o_err[0]);
        end
        @(negedge clk); #1;
        total++;
        if (o_gnt[0] !== '0) begin
            bad++; $display("FAIL abort_idle gnt=%h want 0", o_gnt[0]);
        end
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        set_master(1, 2, 1'b0, 32'h1000_0000, 32'h0);
        @(negedge clk); #1;
        total++;
        if (o_sreq[1] !== 8'h02 || o_gnt[1] !== 4'b0100) begin
            bad++; $display("FAIL rstmid_busy sreq=%h gnt=%h want 02 4", o_sreq[1], o_gnt[1]);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (o_sreq[1] !== 8'h00 || o_gnt[1] !== '0 || o_ready[1] !== '0) begin
            bad++; $display("FAIL rstmid_drop sreq=%h gnt=%h rdy=%h want 0", o_sreq[1], o_gnt[1], o_ready[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < NM; i++) set_master(1, i, 1'b0, 32'h0000_0000, 32'h0);
        s_ready[1][0] = 1'b1;
        @(negedge clk); #1;
        total++;
        if (o_gnt[1] !== 4'b0001) begin
            bad++; $display("FAIL rstmid_first gnt=%h want 1", o_gnt[1]);
        end
        @(negedge clk);
        m_req[1] = '0;
    endtask

`ifdef RIB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        set_master(0, 0, 1'b0, 32'h3000_0000, 32'h0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk); #1;
            if (k < TO) begin
                total++;
                if (o_ready[0] !== '0 || o_sreq[0] !== 8'h08) begin
                    bad++; $display("FAIL tmo_wait k=%0d rdy=%h sreq=%h want 0 08", k, o_ready[0], o_sreq[0]);
                end
            end else begin
                total++;
                if (o_ready[0] !== 4'b0001 || o_mdata[0] !== 32'hDEAD_BEEF || o_err[0] !== 1'b1) begin
                    bad++; $display("FAIL tmo_fire rdy=%h mdata=%h err=%b want 1 DEADBEEF 1", o_ready[0], o_mdata[0], o_err[0]);
                end
            end
        end
        @(negedge clk);
        m_req[0] = '0;
    endtask
`endif

    task automatic test_random(input int cycles);
        logic [NM-1:0] react [2];
        exp_t e;
        apply_reset();
        react[0] = '0; react[1] = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NM; i++) begin
                    if (react[d][i]) begin
                        if ($urandom_range(0, 1) == 1) new_txn(d, i);
                        else m_req[d][i] = 1'b0;
                    end else if (!m_req[d][i]) begin
                        if ($urandom_range(0, 3) == 0) new_txn(d, i);
                    end else if ($urandom_range(0, 24) == 0) begin
                        m_req[d][i] = 1'b0;
                    end
                end
                for (int j = 0; j < NS; j++) begin
                    s_ready[d][j] = ($urandom_range(0, 2) != 0);
                    s_rdata[d][j*32 +: 32] = $urandom;
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                e = model_expect(d);
                total++;
                if (o_gnt[d] !== e.gnt) begin
                    bad++; $display("FAIL rand_gnt d=%0d cyc=%0d got=%h want=%h", d, c, o_gnt[d], e.gnt);
                end
                total++;
                if (o_ready[d] !== e.ready || o_err[d] !== e.err) begin
                    bad++; $display("FAIL rand_ready d=%0d cyc=%0d rdy=%h err=%b want=%h %b", d, c, o_ready[d], o_err[d], e.ready, e.err);
                end
                total++;
                if (o_mdata[d] !== e.mdata) begin
                    bad++; $display("FAIL rand_mdata d=%0d cyc=%0d got=%h want=%h", d, c, o_mdata[d], e.mdata);
                end
                total++;
                if (o_sreq[d] !== e.sreq || o_swe[d] !== e.swe) begin
                    bad++; $display("FAIL rand_sreq d=%0d cyc=%0d sreq=%h swe=%h want=%h %h", d, c, o_sreq[d], o_swe[d], e.sreq, e.swe);
                end
                total++;
                if (o_saddr[d] !== e.saddr || o_sdata[d] !== e.sdata) begin
                    bad++; $display("FAIL rand_sbus d=%0d cyc=%0d saddr=%h sdata=%h want=%h %h", d, c, o_saddr[d], o_sdata[d], e.saddr, e.sdata);
                end
                total++;
                if (o_hold[d] !== e.hold) begin
                    bad++; $display("FAIL rand_hold d=%0d cyc=%0d got=%b want=%b", d, c, o_hold[d], e.hold);
                end
                react[d] = e.ready;
                model_step(d, e);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        model_reset();
        test_reset();
        test_basic_read();
        test_fixed_priority();
        test_round_robin();
        test_error();
        test_abort();
        test_reset_mid_busy();
`ifdef RIB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
